// File: rtl/pipeline_stall_sequencer.sv
// Pipeline stall/flush sequencer: turns hazard requests into stall, freeze and redirect sequences.
// Latency: RUN outputs are combinational (zero cycle). Sequences last LOAD_STALL_CYC or MDU_LAT-1 cycles.
// Backpressure: the sequencer ignores requests while it is in LSTALL or MDU_BUSY. Optional PIPE_STALL_PERF_EN builds the stall/flush counters.
module pipeline_stall_sequencer #(
    parameter int LOAD_STALL_CYC = 1,
    parameter int MDU_LAT        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_use_haz,
    input  logic        branch_taken,
    input  logic [31:0] bta,
    input  logic        mdu_start,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        mdu_busy,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LSTALL   = 2'd1,
        MDU_BUSY = 2'd2
    } state_e;

    localparam logic [4:0] LSTALL_LOAD = 5'(LOAD_STALL_CYC - 1);
    localparam logic [4:0] MDU_LOAD    = 5'(MDU_LAT - 1);

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (load_use_haz) begin
                    // A one-cycle load stall is fully covered by the RUN cycle itself.
                    if (LOAD_STALL_CYC > 1) begin
                        state_d = LSTALL;
                        cnt_d   = LSTALL_LOAD;
                    end
                end else if (mdu_start) begin
                    state_d = MDU_BUSY;
                    cnt_d   = MDU_LOAD;
                end
            end
            LSTALL, MDU_BUSY: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 5'd0;
            end
        endcase
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_redirect  = 1'b0;
        redirect_pc  = 32'd0;
        mdu_busy     = 1'b0;
        // Reset overrides everything so an in-flight sequence aborts at once.
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (load_use_haz) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end else if (!mdu_start && branch_taken) begin
                        pc_redirect = 1'b1;
                        redirect_pc = bta;
                        if_id_flush = 1'b1;
                    end
                end
                LSTALL: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
                MDU_BUSY: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_flush = 1'b1;
                    mdu_busy     = 1'b1;
                end
                default: begin
                    pc_write = 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (!pc_write && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (pc_redirect && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Directed bench for pipeline_stall_sequencer: one default instance and one with LOAD_STALL_CYC=3.
module tb_pipeline_stall_sequencer;

`ifdef PIPE_STALL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_flush, pc_redirect, mdu_busy}
    localparam logic [7:0] V_DEF = 8'b1110_0000;
    localparam logic [7:0] V_LST = 8'b0010_1000;
    localparam logic [7:0] V_MDU = 8'b0000_0101;
    localparam logic [7:0] V_BR  = 8'b1111_0010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lu_a = 1'b0, br_a = 1'b0, mdu_a = 1'b0;
    logic [31:0] bta_a = 32'd0;
    logic        lu_b = 1'b0;

    logic        a_pcw, a_ifw, a_idw, a_iff, a_idf, a_exf, a_red, a_busy;
    logic [31:0] a_rpc, a_scnt, a_fcnt;
    logic        b_pcw, b_ifw, b_idw, b_iff, b_idf, b_exf, b_red, b_busy;
    logic [31:0] b_rpc, b_scnt, b_fcnt;
    logic [7:0]  a_vec, b_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign a_vec = {a_pcw, a_ifw, a_idw, a_iff, a_idf, a_exf, a_red, a_busy};
    assign b_vec = {b_pcw, b_ifw, b_idw, b_iff, b_idf, b_exf, b_red, b_busy};

    pipeline_stall_sequencer #(.LOAD_STALL_CYC(1), .MDU_LAT(4)) u_dut_a (
        .clk(clk), .rst(rst), .load_use_haz(lu_a), .branch_taken(br_a), .bta(bta_a),
        .mdu_start(mdu_a), .pc_write(a_pcw), .if_id_write(a_ifw), .id_ex_write(a_idw),
        .if_id_flush(a_iff), .id_ex_flush(a_idf), .ex_mem_flush(a_exf), .pc_redirect(a_red),
        .redirect_pc(a_rpc), .mdu_busy(a_busy), .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
    );

    pipeline_stall_sequencer #(.LOAD_STALL_CYC(3), .MDU_LAT(4)) u_dut_b (
        .clk(clk), .rst(rst), .load_use_haz(lu_b), .branch_taken(1'b0), .bta(32'd0),
        .mdu_start(1'b0), .pc_write(b_pcw), .if_id_write(b_ifw), .id_ex_write(b_idw),
        .if_id_flush(b_iff), .id_ex_flush(b_idf), .ex_mem_flush(b_exf), .pc_redirect(b_red),
        .redirect_pc(b_rpc), .mdu_busy(b_busy), .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset: defaults even with requests asserted
        @(negedge clk);
        check("rst_outs", {24'd0, a_vec}, {24'd0, V_DEF});
        check("rst_rpc", a_rpc, 32'd0);
        check("rst_scnt", a_scnt, 32'd0);
        check("rst_fcnt", a_fcnt, 32'd0);
        lu_a = 1'b1; br_a = 1'b1; bta_a = 32'hDEAD_BEEF;
        #1;
        check("rst_force", {24'd0, a_vec}, {24'd0, V_DEF});
        check("rst_force_rpc", a_rpc, 32'd0);

        next_cyc();
        rst = 1'b0; lu_a = 1'b0; br_a = 1'b0; bta_a = 32'd0;
        @(negedge clk);
        check("idle", {24'd0, a_vec}, {24'd0, V_DEF});

        // Single-cycle load-use stall
        next_cyc(); lu_a = 1'b1;
        @(negedge clk);
        check("lu1_T", {24'd0, a_vec}, {24'd0, V_LST});
        next_cyc(); lu_a = 1'b0;
        @(negedge clk);
        check("lu1_T1", {24'd0, a_vec}, {24'd0, V_DEF});
        check("lu1_scnt", a_scnt, cnt_exp(1));

        // Back-to-back load-use stalls, no dead cycle
        next_cyc(); lu_a = 1'b1;
        @(negedge clk);
        check("b2b_0", {24'd0, a_vec}, {24'd0, V_LST});
        next_cyc();
        @(negedge clk);
        check("b2b_1", {24'd0, a_vec}, {24'd0, V_LST});
        next_cyc(); lu_a = 1'b0;
        @(negedge clk);
        check("b2b_end", {24'd0, a_vec}, {24'd0, V_DEF});
        check("b2b_scnt", a_scnt, cnt_exp(3));

        // Three-cycle load stall on instance B, request held for three cycles
        for (int i = 0; i < 3; i++) begin
            next_cyc(); lu_b = 1'b1;
            @(negedge clk);
            check($sformatf("lu3_c%0d", i), {24'd0, b_vec}, {24'd0, V_LST});
        end
        next_cyc(); lu_b = 1'b0;
        @(negedge clk);
        check("lu3_end", {24'd0, b_vec}, {24'd0, V_DEF});
        check("lu3_scnt", b_scnt, cnt_exp(3));

        // Taken branch, same-cycle redirect
        next_cyc(); br_a = 1'b1; bta_a = 32'h0040_0020;
        @(negedge clk);
        check("br_outs", {24'd0, a_vec}, {24'd0, V_BR});
        check("br_rpc", a_rpc, 32'h0040_0020);
        next_cyc(); br_a = 1'b0;
        @(negedge clk);
        check("br_after", {24'd0, a_vec}, {24'd0, V_DEF});
        check("br_after_rpc", a_rpc, 32'd0);
        check("br_fcnt", a_fcnt, cnt_exp(1));

        // Load-use beats branch
        next_cyc(); lu_a = 1'b1; br_a = 1'b1; bta_a = 32'h0000_1234;
        @(negedge clk);
        check("lubr_outs", {24'd0, a_vec}, {24'd0, V_LST});
        check("lubr_rpc", a_rpc, 32'd0);
        next_cyc(); lu_a = 1'b0; br_a = 1'b0;
        @(negedge clk);
        check("lubr_scnt", a_scnt, cnt_exp(4));
        check("lubr_fcnt", a_fcnt, cnt_exp(1));

        // MDU sequence, branch during freeze is ignored
        next_cyc(); mdu_a = 1'b1;
        @(negedge clk);
        check("mdu_T", {24'd0, a_vec}, {24'd0, V_DEF});
        next_cyc(); mdu_a = 1'b0; br_a = 1'b1; bta_a = 32'h0000_8000;
        for (int i = 1; i < 4; i++) begin
            if (i > 1) next_cyc();
            @(negedge clk);
            check($sformatf("mdu_T%0d", i), {24'd0, a_vec}, {24'd0, V_MDU});
            check($sformatf("mdu_rpc%0d", i), a_rpc, 32'd0);
        end
        next_cyc();
        @(negedge clk);
        check("mdu_T4_br", {24'd0, a_vec}, {24'd0, V_BR});
        check("mdu_T4_rpc", a_rpc, 32'h0000_8000);
        next_cyc(); br_a = 1'b0;
        @(negedge clk);
        check("mdu_scnt", a_scnt, cnt_exp(7));
        check("mdu_fcnt", a_fcnt, cnt_exp(2));

        // mdu_start with coincident branch, then reset mid-freeze
        next_cyc(); mdu_a = 1'b1; br_a = 1'b1; bta_a = 32'h0000_4444;
        @(negedge clk);
        check("mdubr_outs", {24'd0, a_vec}, {24'd0, V_DEF});
        check("mdubr_rpc", a_rpc, 32'd0);
        next_cyc(); mdu_a = 1'b0; br_a = 1'b0;
        @(negedge clk);
        check("abort_T1", {24'd0, a_vec}, {24'd0, V_MDU});
        next_cyc();
        @(negedge clk);
        check("abort_T2", {24'd0, a_vec}, {24'd0, V_MDU});
        #1 rst = 1'b1;
        #1;
        check("abort_outs", {24'd0, a_vec}, {24'd0, V_DEF});
        check("abort_busy", {31'd0, a_busy}, 32'd0);
        check("abort_scnt", a_scnt, 32'd0);
        check("abort_fcnt", a_fcnt, 32'd0);
        next_cyc();
        next_cyc(); rst = 1'b0; lu_a = 1'b1;
        @(negedge clk);
        check("post_lu", {24'd0, a_vec}, {24'd0, V_LST});
        next_cyc(); lu_a = 1'b0;
        @(negedge clk);
        check("post_def", {24'd0, a_vec}, {24'd0, V_DEF});
        check("post_scnt", a_scnt, cnt_exp(1));
        check("post_fcnt", a_fcnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
